// File: rtl/croc_pkg.sv
// Shared SoC types and constants for the peripheral OBI crossbar and the regbus.
package croc_pkg;

   localparam int unsigned SbrObiIdWidth = 4;

   localparam int unsigned ObiRegTimeoutCycles = 256;
   localparam logic [31:0] ObiRegErrData       = 32'hBADCAB1E;

   typedef struct packed {
      logic [31:0]              addr;
      logic                     we;
      logic [3:0]               be;
      logic [31:0]              wdata;
      logic [SbrObiIdWidth-1:0] aid;
   } sbr_obi_a_chan_t;

   typedef struct packed {
      logic            req;
      sbr_obi_a_chan_t a;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0]              rdata;
      logic [SbrObiIdWidth-1:0] rid;
      logic                     err;
      logic                     r_optional;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   // Reads must present an all-zero strobe on the regbus.
   function automatic logic [3:0] reg_wstrb(input logic we, input logic [3:0] be);
      return we ? be : 4'h0;
   endfunction

endpackage

// File: rtl/croc_obi_to_reg.sv
// OBI subordinate to regbus bridge, one transaction in flight.
// Optional regbus timeout enabled by defining CROC_OBI2REG_TIMEOUT_EN.
//
//   state | meaning
//   Idle  | grant follows req; on grant latch the A-phase and go to Reg
//   Reg   | regbus valid held with latched fields until ready (or timeout)
//   Resp  | OBI rvalid for one cycle with captured rdata/err and rid
module croc_obi_to_reg
   import croc_pkg::*;
#(
   parameter type         obi_req_t     = sbr_obi_req_t,
   parameter type         obi_rsp_t     = sbr_obi_rsp_t,
   parameter type         reg_req_t     = croc_pkg::reg_req_t,
   parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
   parameter int unsigned TimeoutCycles = ObiRegTimeoutCycles
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t obi_req_i,
   output obi_rsp_t obi_rsp_o,
   output reg_req_t reg_req_o,
   input  reg_rsp_t reg_rsp_i
);

   localparam int unsigned IdWidth = $bits(obi_req_i.a.aid);

   typedef enum logic [1:0] {Idle, Reg, Resp} state_e;

   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("TimeoutCycles must be at least 1");
   end

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic                 we_q, we_d;
   logic [3:0]           be_q, be_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;

`ifdef CROC_OBI2REG_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   logic [CntWidth-1:0]  cnt_q, cnt_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      id_d    = id_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef CROC_OBI2REG_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif

      unique case (state_q)
         Idle: begin
            if (obi_req_i.req) begin
               addr_d  = obi_req_i.a.addr;
               we_d    = obi_req_i.a.we;
               be_d    = obi_req_i.a.be;
               wdata_d = obi_req_i.a.wdata;
               id_d    = obi_req_i.a.aid;
               state_d = Reg;
`ifdef CROC_OBI2REG_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         Reg: begin
            // A ready in the last allowed cycle takes priority over the timeout.
            if (reg_rsp_i.ready) begin
               rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
               err_d   = reg_rsp_i.error;
               state_d = Resp;
            end
`ifdef CROC_OBI2REG_TIMEOUT_EN
            else if (cnt_q == CntLast) begin
               rdata_d = ObiRegErrData;
               err_d   = 1'b1;
               state_d = Resp;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
`endif
         end
         Resp: begin
            state_d = Idle;
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   always_comb begin
      obi_rsp_o            = '0;
      obi_rsp_o.gnt        = (state_q == Idle) && obi_req_i.req;
      obi_rsp_o.rvalid     = (state_q == Resp);
      obi_rsp_o.r.rdata    = rdata_q;
      obi_rsp_o.r.rid      = id_q;
      obi_rsp_o.r.err      = err_q;
      obi_rsp_o.r.r_optional = '0;

      reg_req_o       = '0;
      reg_req_o.valid = (state_q == Reg);
      reg_req_o.addr  = addr_q;
      reg_req_o.write = we_q;
      reg_req_o.wdata = wdata_q;
      reg_req_o.wstrb = reg_wstrb(we_q, be_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         id_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         id_q    <= id_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

`ifdef CROC_OBI2REG_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_croc_obi_to_reg.sv
// Directed bench for the OBI-to-regbus bridge; timeout vectors run only when
// CROC_OBI2REG_TIMEOUT_EN is defined.
module tb_croc_obi_to_reg;
   import croc_pkg::*;

   logic         clk_i;
   logic         rst_ni;
   sbr_obi_req_t obi_req_i;
   sbr_obi_rsp_t obi_rsp_o;
   reg_req_t     reg_req_o;
   reg_rsp_t     reg_rsp_i;

   int vectors;
   int miscompares;

   croc_obi_to_reg #(
      .obi_req_t     (sbr_obi_req_t),
      .obi_rsp_t     (sbr_obi_rsp_t),
      .reg_req_t     (reg_req_t),
      .reg_rsp_t     (reg_rsp_t),
      .TimeoutCycles (8)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .obi_req_i (obi_req_i),
      .obi_rsp_o (obi_rsp_o),
      .reg_req_o (reg_req_o),
      .reg_rsp_i (reg_rsp_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic obi_issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [3:0] aid);
      obi_req_i.req     = 1'b1;
      obi_req_i.a.addr  = addr;
      obi_req_i.a.we    = we;
      obi_req_i.a.be    = be;
      obi_req_i.a.wdata = wdata;
      obi_req_i.a.aid   = aid;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_ni      = 1'b0;
      obi_req_i   = '0;
      reg_rsp_i   = '0;

      // Reset state
      #3;
      chk("rst_gnt",    {31'b0, obi_rsp_o.gnt},    32'h0);
      chk("rst_rvalid", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      chk("rst_valid",  {31'b0, reg_req_o.valid},  32'h0);
      chk("rst_addr",   reg_req_o.addr,            32'h0);
      chk("rst_wstrb",  {28'b0, reg_req_o.wstrb},  32'h0);
      chk("rst_rdata",  obi_rsp_o.r.rdata,         32'h0);
      nxt();
      nxt();
      rst_ni = 1'b1;

      // 1: read, zero wait states
      nxt();
      obi_issue(32'h0300_5004, 1'b0, 4'hF, 32'h0, 4'd3);
      reg_rsp_i = '{rdata: 32'hA5A5_0001, error: 1'b0, ready: 1'b1};
      settle();
      chk("t1_gnt_c0",   {31'b0, obi_rsp_o.gnt},   32'h1);
      chk("t1_valid_c0", {31'b0, reg_req_o.valid}, 32'h0);
      nxt();
      obi_req_i.req = 1'b0;
      settle();
      chk("t1_valid_c1", {31'b0, reg_req_o.valid}, 32'h1);
      chk("t1_addr_c1",  reg_req_o.addr,           32'h0300_5004);
      chk("t1_write_c1", {31'b0, reg_req_o.write}, 32'h0);
      chk("t1_wstrb_c1", {28'b0, reg_req_o.wstrb}, 32'h0);
      chk("t1_gnt_c1",   {31'b0, obi_rsp_o.gnt},   32'h0);
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t1_rvalid_c2", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t1_rdata_c2",  obi_rsp_o.r.rdata,          32'hA5A5_0001);
      chk("t1_rid_c2",    {28'b0, obi_rsp_o.r.rid},   32'd3);
      chk("t1_err_c2",    {31'b0, obi_rsp_o.r.err},   32'h0);
      chk("t1_valid_c2",  {31'b0, reg_req_o.valid},   32'h0);
      nxt();
      settle();
      chk("t1_rvalid_c3", {31'b0, obi_rsp_o.rvalid}, 32'h0);

      // 2: write, three wait states (valid held four cycles)
      nxt();
      obi_issue(32'h0300_0008, 1'b1, 4'b0011, 32'hDEAD_BEEF, 4'd5);
      settle();
      chk("t2_gnt_c0", {31'b0, obi_rsp_o.gnt}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         nxt();
         obi_req_i.req = 1'b0;
         reg_rsp_i = '{rdata: 32'h1234_5678, error: 1'b0, ready: (i == 3)};
         settle();
         chk("t2_valid",  {31'b0, reg_req_o.valid},  32'h1);
         chk("t2_write",  {31'b0, reg_req_o.write},  32'h1);
         chk("t2_wstrb",  {28'b0, reg_req_o.wstrb},  32'h3);
         chk("t2_addr",   reg_req_o.addr,            32'h0300_0008);
         chk("t2_wdata",  reg_req_o.wdata,           32'hDEAD_BEEF);
         chk("t2_rvalid", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      end
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t2_rvalid_resp", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t2_err_resp",    {31'b0, obi_rsp_o.r.err},  32'h0);
      chk("t2_rdata_resp",  obi_rsp_o.r.rdata,         32'h0);
      chk("t2_rid_resp",    {28'b0, obi_rsp_o.r.rid},  32'd5);
      chk("t2_valid_resp",  {31'b0, reg_req_o.valid},  32'h0);

      // 3: error propagation on a read
      nxt();
      obi_issue(32'h0300_1000, 1'b0, 4'hF, 32'h0, 4'd9);
      settle();
      nxt();
      obi_req_i.req = 1'b0;
      reg_rsp_i = '{rdata: 32'h0BAD_0000, error: 1'b1, ready: 1'b1};
      settle();
      chk("t3_valid", {31'b0, reg_req_o.valid}, 32'h1);
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t3_rvalid", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t3_err",    {31'b0, obi_rsp_o.r.err},  32'h1);
      chk("t3_rid",    {28'b0, obi_rsp_o.r.rid},  32'd9);
      chk("t3_rdata",  obi_rsp_o.r.rdata,         32'h0BAD_0000);

      // 4: back-to-back with req held high
      nxt();
      obi_issue(32'h0300_2000, 1'b0, 4'hF, 32'h0, 4'd1);
      reg_rsp_i = '{rdata: 32'h1111_1111, error: 1'b0, ready: 1'b1};
      settle();
      chk("t4_gnt_c0", {31'b0, obi_rsp_o.gnt}, 32'h1);
      nxt();
      obi_issue(32'h0300_2004, 1'b0, 4'hF, 32'h0, 4'd2);
      settle();
      chk("t4_gnt_c1",  {31'b0, obi_rsp_o.gnt},   32'h0);
      chk("t4_addr_c1", reg_req_o.addr,           32'h0300_2000);
      nxt();
      reg_rsp_i.rdata = 32'h2222_2222;
      settle();
      chk("t4_gnt_c2",    {31'b0, obi_rsp_o.gnt},    32'h0);
      chk("t4_rvalid_c2", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t4_rid_c2",    {28'b0, obi_rsp_o.r.rid},  32'd1);
      chk("t4_rdata_c2",  obi_rsp_o.r.rdata,         32'h1111_1111);
      nxt();
      settle();
      chk("t4_gnt_c3",    {31'b0, obi_rsp_o.gnt},    32'h1);
      chk("t4_rvalid_c3", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      nxt();
      obi_req_i.req = 1'b0;
      settle();
      chk("t4_gnt_c4",  {31'b0, obi_rsp_o.gnt}, 32'h0);
      chk("t4_addr_c4", reg_req_o.addr,         32'h0300_2004);
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t4_rvalid_c5", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t4_rid_c5",    {28'b0, obi_rsp_o.r.rid},  32'd2);
      chk("t4_rdata_c5",  obi_rsp_o.r.rdata,         32'h2222_2222);

      // 5: asynchronous reset while in Reg
      nxt();
      obi_issue(32'h0300_3000, 1'b0, 4'hF, 32'h0, 4'd7);
      settle();
      nxt();
      obi_req_i.req = 1'b0;
      settle();
      chk("t5_valid_pre", {31'b0, reg_req_o.valid}, 32'h1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t5_valid_rst",  {31'b0, reg_req_o.valid},  32'h0);
      chk("t5_gnt_rst",    {31'b0, obi_rsp_o.gnt},    32'h0);
      chk("t5_rvalid_rst", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      nxt();
      rst_ni = 1'b1;
      nxt();
      obi_issue(32'h0300_3004, 1'b0, 4'hF, 32'h0, 4'd6);
      reg_rsp_i = '{rdata: 32'h600D_F00D, error: 1'b0, ready: 1'b1};
      settle();
      chk("t5_gnt_fresh", {31'b0, obi_rsp_o.gnt}, 32'h1);
      nxt();
      obi_req_i.req = 1'b0;
      settle();
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t5_rvalid_fresh", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t5_rdata_fresh",  obi_rsp_o.r.rdata,         32'h600D_F00D);
      chk("t5_rid_fresh",    {28'b0, obi_rsp_o.r.rid},  32'd6);

`ifdef CROC_OBI2REG_TIMEOUT_EN
      // 6a: peripheral never ready, timeout after 8 valid cycles
      nxt();
      obi_issue(32'h0300_4000, 1'b0, 4'hF, 32'h0, 4'd4);
      settle();
      for (int i = 0; i < 8; i++) begin
         nxt();
         obi_req_i.req = 1'b0;
         settle();
         chk("t6_valid_wait",  {31'b0, reg_req_o.valid},  32'h1);
         chk("t6_rvalid_wait", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      end
      nxt();
      reg_rsp_i = '{rdata: 32'h7777_7777, error: 1'b0, ready: 1'b1};
      settle();
      chk("t6_rvalid_to", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t6_err_to",    {31'b0, obi_rsp_o.r.err},  32'h1);
      chk("t6_rdata_to",  obi_rsp_o.r.rdata,         32'hBADC_AB1E);
      chk("t6_valid_to",  {31'b0, reg_req_o.valid},  32'h0);
      nxt();
      settle();
      chk("t6_rvalid_late", {31'b0, obi_rsp_o.rvalid}, 32'h0);
      chk("t6_valid_late",  {31'b0, reg_req_o.valid},  32'h0);
      chk("t6_rdata_late",  obi_rsp_o.r.rdata,         32'hBADC_AB1E);
      reg_rsp_i = '0;

      // 6b: ready in the eighth cycle wins over the timeout
      nxt();
      obi_issue(32'h0300_4004, 1'b0, 4'hF, 32'h0, 4'd8);
      settle();
      for (int i = 0; i < 8; i++) begin
         nxt();
         obi_req_i.req = 1'b0;
         reg_rsp_i = '{rdata: 32'h8888_0008, error: 1'b0, ready: (i == 7)};
         settle();
         chk("t6b_valid", {31'b0, reg_req_o.valid}, 32'h1);
      end
      nxt();
      reg_rsp_i = '0;
      settle();
      chk("t6b_rvalid", {31'b0, obi_rsp_o.rvalid}, 32'h1);
      chk("t6b_err",    {31'b0, obi_rsp_o.r.err},  32'h0);
      chk("t6b_rdata",  obi_rsp_o.r.rdata,         32'h8888_0008);
`endif

      nxt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
